// File: rtl/vga_controller_pkg.sv
// Shared VGA 640x480@60 timing constants for the controller and pixel-generation logic.
// Package vga_timing_pkg; the optional VGA_SYNC_ACTIVE_HIGH_EN macro is consumed by vga_controller.
package vga_timing_pkg;

    localparam int unsigned H_VISIBLE = 32'd640;
    localparam int unsigned H_FRONT   = 32'd16;
    localparam int unsigned H_SYNC    = 32'd96;
    localparam int unsigned H_BACK    = 32'd48;
    localparam int unsigned V_VISIBLE = 32'd480;
    localparam int unsigned V_FRONT   = 32'd10;
    localparam int unsigned V_SYNC    = 32'd2;
    localparam int unsigned V_BACK    = 32'd33;

    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam int unsigned CNT_W     = 32'd10;
    localparam int unsigned MAX_TOTAL = 32'd1 << CNT_W;

endpackage

// File: rtl/vga_controller_if.sv
// Timing bundle from vga_controller to downstream pixel-generation logic.
interface vga_controller_if;
    import vga_timing_pkg::CNT_W;

    logic             h_sync;
    logic             v_sync;
    logic             display_enable;
    logic [CNT_W-1:0] x_count;
    logic [CNT_W-1:0] y_count;
    logic             frame_end;

    modport master (output h_sync, v_sync, display_enable, x_count, y_count, frame_end);
    modport slave  (input  h_sync, v_sync, display_enable, x_count, y_count, frame_end);

endinterface

// File: rtl/vga_controller_axis_counter.sv
// Wrapping axis counter (0..TERMINAL) with count enable and a same-cycle wrap pulse.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned TERMINAL = H_TOTAL - 32'd1
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count,
    output logic             o_wrap
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(TERMINAL);

    logic [CNT_W-1:0] r_count;
    logic             w_at_term;

    assign w_at_term = (r_count == TERM);
    assign o_wrap    = i_en & w_at_term;
    assign o_count   = r_count;

    // Count register: reset wins, then wrap at terminal, else increment when enabled.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_en) begin
            if (w_at_term) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/vga_controller.sv
// VGA timing generator: chained x/y counters plus zero-latency sync/enable decode.
// Define VGA_SYNC_ACTIVE_HIGH_EN for active-high syncs (idle/reset level 0).
module vga_controller #(
    parameter int unsigned H_VISIBLE = vga_timing_pkg::H_VISIBLE,
    parameter int unsigned H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int unsigned H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BACK    = vga_timing_pkg::H_BACK,
    parameter int unsigned V_VISIBLE = vga_timing_pkg::V_VISIBLE,
    parameter int unsigned V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int unsigned V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BACK    = vga_timing_pkg::V_BACK
) (
    input  logic              clk,
    input  logic              reset,
    vga_controller_if.master  vga
);
    import vga_timing_pkg::CNT_W;
    import vga_timing_pkg::MAX_TOTAL;

    localparam int unsigned H_SPAN = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_SPAN = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] X_VIS    = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] Y_VIS    = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 32'd1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 32'd1);

    // Totals must fit the 10-bit counters.
    if ((H_SPAN > MAX_TOTAL) || (V_SPAN > MAX_TOTAL)) begin : g_cfg_error
        $error("vga_controller: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    logic [CNT_W-1:0] w_x;
    logic [CNT_W-1:0] w_y;
    logic             w_h_wrap;
    logic             w_v_wrap;
    logic             w_h_active;
    logic             w_v_active;

    vga_axis_counter #(.TERMINAL(H_SPAN - 32'd1)) u_h_counter (
        .clk     (clk),
        .i_rst_n (reset),
        .i_en    (1'b1),
        .o_count (w_x),
        .o_wrap  (w_h_wrap)
    );

    vga_axis_counter #(.TERMINAL(V_SPAN - 32'd1)) u_v_counter (
        .clk     (clk),
        .i_rst_n (reset),
        .i_en    (w_h_wrap),
        .o_count (w_y),
        .o_wrap  (w_v_wrap)
    );

    assign w_h_active = (w_x >= HS_FIRST) && (w_x <= HS_LAST);
    assign w_v_active = (w_y >= VS_FIRST) && (w_y <= VS_LAST);

`ifdef VGA_SYNC_ACTIVE_HIGH_EN
    assign vga.h_sync = w_h_active;
    assign vga.v_sync = w_v_active;
`else
    assign vga.h_sync = ~w_h_active;
    assign vga.v_sync = ~w_v_active;
`endif

    assign vga.display_enable = (w_x < X_VIS) && (w_y < Y_VIS);
    assign vga.x_count        = w_x;
    assign vga.y_count        = w_y;
    assign vga.frame_end      = w_v_wrap;

endmodule

// File: tb/tb_vga_controller.sv
// Self-checking bench: full-size and shrunken-timing controllers against a pixel-index model.
module tb_vga_controller;

    typedef struct {
        int hv; int hf; int hs; int hb;
        int vv; int vf; int vs; int vb;
    } cfg_t;

    typedef struct {
        int n;
        int x;
        int y;
        bit de;
        bit hs_a;
        bit vs_a;
    } vec_t;

`ifdef VGA_SYNC_ACTIVE_HIGH_EN
    localparam bit SYNC_HI = 1'b1;
`else
    localparam bit SYNC_HI = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_a = 1'b0;
    logic reset_b = 1'b0;

    vga_controller_if bus_a();
    vga_controller_if bus_b();

    vga_controller u_full (
        .clk   (clk),
        .reset (reset_a),
        .vga   (bus_a)
    );

    vga_controller #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) u_small (
        .clk   (clk),
        .reset (reset_b),
        .vga   (bus_b)
    );

    always #20 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    longint n_a = 0;
    longint n_b = 0;
    bit     valid_a = 1'b0;
    bit     valid_b = 1'b0;
    cfg_t   cfg_a = '{640, 16, 96, 48, 480, 10, 2, 33};
    cfg_t   cfg_b = '{8, 2, 3, 2, 4, 1, 2, 1};

    function automatic logic lvl(input bit asserted);
        return SYNC_HI ? asserted : !asserted;
    endfunction

    // Reference: position is the pixel index since reset, folded by the frame size.
    function automatic void model(input cfg_t c, input longint n, output int x, output int y,
                                  output bit de, output bit hsa, output bit vsa, output bit fe);
        int     ht = c.hv + c.hf + c.hs + c.hb;
        int     vt = c.vv + c.vf + c.vs + c.vb;
        longint p  = n % longint'(ht * vt);
        x   = int'(p % ht);
        y   = int'(p / ht);
        de  = (x < c.hv) && (y < c.vv);
        hsa = (x >= c.hv + c.hf) && (x < c.hv + c.hf + c.hs);
        vsa = (y >= c.vv + c.vf) && (y < c.vv + c.vf + c.vs);
        fe  = (p == longint'(ht * vt - 1));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag, input cfg_t c, input longint n,
                               input logic [9:0] x, input logic [9:0] y, input logic de,
                               input logic hs, input logic vs, input logic fe);
        int ex, ey;
        bit ede, ehs, evs, efe;
        model(c, n, ex, ey, ede, ehs, evs, efe);
        chk({tag, " x"}, 32'(x), ex);
        chk({tag, " y"}, 32'(y), ey);
        chk({tag, " de"}, 32'(de), 32'(ede));
        chk({tag, " hsync"}, 32'(hs), 32'(lvl(ehs)));
        chk({tag, " vsync"}, 32'(vs), 32'(lvl(evs)));
        chk({tag, " frame_end"}, 32'(fe), 32'(efe));
    endtask

    // One clock: advance the model at the edge, then compare both DUTs 1 time unit later.
    task automatic step();
        @(posedge clk);
        if (!reset_a) begin n_a = 0; valid_a = 1'b1; end else n_a++;
        if (!reset_b) begin n_b = 0; valid_b = 1'b1; end else n_b++;
        #1;
        if (valid_a) check_model("full", cfg_a, n_a, bus_a.x_count, bus_a.y_count,
                                 bus_a.display_enable, bus_a.h_sync, bus_a.v_sync, bus_a.frame_end);
        if (valid_b) check_model("small", cfg_b, n_b, bus_b.x_count, bus_b.y_count,
                                 bus_b.display_enable, bus_b.h_sync, bus_b.v_sync, bus_b.frame_end);
    endtask

    initial begin
        vec_t vecs[11];
        int   cnt_hs, cnt_de, first_hs, last_hs, cnt_vs;

        vecs[0]  = '{0,    0,   0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1,    1,   0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{639,  639, 0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{640,  640, 0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{655,  655, 0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{656,  656, 0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{751,  751, 0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{752,  752, 0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{799,  799, 0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{800,  0,   1, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1605, 5,   2, 1'b1, 1'b0, 1'b0};

        // Reset held for 5 clocks: both DUTs sit at pixel (0,0).
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst x", 32'(bus_a.x_count), 32'd0);
            chk("rst y", 32'(bus_a.y_count), 32'd0);
            chk("rst de", 32'(bus_a.display_enable), 32'd1);
            chk("rst hsync", 32'(bus_a.h_sync), 32'(lvl(1'b0)));
            chk("rst vsync", 32'(bus_a.v_sync), 32'(lvl(1'b0)));
            chk("rst small hsync", 32'(bus_b.h_sync), 32'(lvl(1'b0)));
        end
        reset_a = 1'b1;
        reset_b = 1'b1;

        foreach (vecs[i]) begin
            while (n_a < longint'(vecs[i].n)) step();
            chk($sformatf("vec%0d x", i), 32'(bus_a.x_count), 32'(vecs[i].x));
            chk($sformatf("vec%0d y", i), 32'(bus_a.y_count), 32'(vecs[i].y));
            chk($sformatf("vec%0d de", i), 32'(bus_a.display_enable), 32'(vecs[i].de));
            chk($sformatf("vec%0d hsync", i), 32'(bus_a.h_sync), 32'(lvl(vecs[i].hs_a)));
            chk($sformatf("vec%0d vsync", i), 32'(bus_a.v_sync), 32'(lvl(vecs[i].vs_a)));
        end

        // One full line on the full-size DUT from a fresh reset.
        reset_a = 1'b0;
        step();
        reset_a = 1'b1;
        cnt_hs = 0; cnt_de = 0; first_hs = -1; last_hs = -1;
        for (int i = 0; i < 800; i++) begin
            if (bus_a.h_sync === lvl(1'b1)) begin
                cnt_hs++;
                if (first_hs < 0) first_hs = int'(bus_a.x_count);
                last_hs = int'(bus_a.x_count);
            end
            if (bus_a.display_enable === 1'b1) cnt_de++;
            step();
        end
        chk("line hsync clocks", 32'(cnt_hs), 32'd96);
        chk("line hsync first x", 32'(first_hs), 32'd656);
        chk("line hsync last x", 32'(last_hs), 32'd751);
        chk("line de clocks", 32'(cnt_de), 32'd640);
        chk("line wrap x", 32'(bus_a.x_count), 32'd0);
        chk("line wrap y", 32'(bus_a.y_count), 32'd1);

        // Mid-line reset at x=300: straight back to (0,0), then 1, 2.
        while ((n_a % 800) != 300) step();
        chk("pre-reset x", 32'(bus_a.x_count), 32'd300);
        reset_a = 1'b0;
        step();
        chk("midreset x", 32'(bus_a.x_count), 32'd0);
        chk("midreset y", 32'(bus_a.y_count), 32'd0);
        reset_a = 1'b1;
        step();
        chk("resume x1", 32'(bus_a.x_count), 32'd1);
        step();
        chk("resume x2", 32'(bus_a.x_count), 32'd2);
        chk("resume y", 32'(bus_a.y_count), 32'd0);

        // Shrunken 15x8 frame: boundaries, vsync/de totals, and the double wrap.
        reset_b = 1'b0;
        step();
        reset_b = 1'b1;
        cnt_vs = 0; cnt_de = 0;
        for (int i = 0; i < 120; i++) begin
            if (bus_b.v_sync === lvl(1'b1)) cnt_vs++;
            if (bus_b.display_enable === 1'b1) cnt_de++;
            if (i == 52) begin
                chk("small last vis x", 32'(bus_b.x_count), 32'd7);
                chk("small last vis y", 32'(bus_b.y_count), 32'd3);
                chk("small last vis de", 32'(bus_b.display_enable), 32'd1);
            end
            if (i == 60) begin
                chk("small y4 y", 32'(bus_b.y_count), 32'd4);
                chk("small y4 de", 32'(bus_b.display_enable), 32'd0);
            end
            if (i == 119) begin
                chk("small end x", 32'(bus_b.x_count), 32'd14);
                chk("small end y", 32'(bus_b.y_count), 32'd7);
            end
            step();
        end
        chk("small vsync clocks", 32'(cnt_vs), 32'd30);
        chk("small de clocks", 32'(cnt_de), 32'd32);
        chk("small wrap x", 32'(bus_b.x_count), 32'd0);
        chk("small wrap y", 32'(bus_b.y_count), 32'd0);
        chk("small wrap de", 32'(bus_b.display_enable), 32'd1);

        // Random free-running with sporadic one-clock resets, checked by the model.
        for (int i = 0; i < 4000; i++) begin
            reset_a = ($urandom_range(0, 299) != 0);
            reset_b = ($urandom_range(0, 99) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
